// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: add/sub/or/and in one cycle, iterative mul/div/rem
// Operands latch on accept; result and flags are held until the consumer takes them.
module alu_mc #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             stat_zero,
    output logic             stat_sign,
    output logic             stat_overflow,
    output logic             stat_carry
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, out_q, out_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, acc_step;
    logic                 zero_q, zero_d, sign_q, sign_d, ovf_q, ovf_d, carry_q, carry_d;
    logic [WIDTH:0]       sum, diff, mac, rsh, rdiff;
    logic [WIDTH-1:0]     res;
    logic                 res_c, res_v, load, iterative;

    // acc holds {high, low}: mul = {partial product, multiplier}, div = {remainder, dividend/quotient}
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        mac   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        rsh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rdiff = rsh - {1'b0, b_q};
        if (op_q == 3'b100) begin
            acc_step = {mac, acc_q[WIDTH-1:1]};
        end else if (!rdiff[WIDTH]) begin
            acc_step = {rdiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        if (state_q == IDLE) begin
            case (control)
                3'b000: begin
                    res   = sum[WIDTH-1:0];
                    res_c = sum[WIDTH];
                    res_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                end
                3'b001: begin
                    res   = diff[WIDTH-1:0];
                    res_c = diff[WIDTH];
                    res_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                end
                3'b010:  res = a | b;
                3'b011:  res = a & b;
                default: res_v = 1'b1;
            endcase
        end else begin
            case (op_q)
                3'b100: begin
                    res   = acc_step[WIDTH-1:0];
                    res_v = |acc_step[2*WIDTH-1:WIDTH];
                end
                3'b101: begin
                    res   = acc_step[WIDTH-1:0];
                    res_v = (b_q == '0);
                end
                default: begin
                    res   = acc_step[2*WIDTH-1:WIDTH];
                    res_v = (b_q == '0);
                end
            endcase
        end
    end

    assign iterative = control[2] && (control != 3'b111);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    op_d = control;
                    a_d  = a;
                    b_d  = b;
                    if (iterative) begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                        acc_d   = {{WIDTH{1'b0}}, (control == 3'b100) ? b : a};
                    end else begin
                        state_d = DONE;
                        load    = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step;
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    // the last iteration's result is written on the same edge
                    if (cnt_q <= CW'(1)) begin
                        state_d = DONE;
                        load    = 1'b1;
                    end
                end
            end
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        out_d   = load ? res : out_q;
        zero_d  = load ? (res == '0) : zero_q;
        sign_d  = load ? res[WIDTH-1] : sign_q;
        ovf_d   = load ? res_v : ovf_q;
        carry_d = load ? res_c : carry_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            carry_q <= carry_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign out           = out_q;
    assign stat_zero     = zero_q;
    assign stat_sign     = sign_q;
    assign stat_overflow = ovf_q;
    assign stat_carry    = carry_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc
module tb_alu_mc;
    localparam int W = 18;

    typedef struct packed {
        logic [W-1:0] val;
        logic z, s, v, c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic stat_zero, stat_sign, stat_overflow, stat_carry;
    logic [2:0] control;
    logic [W-1:0] a, b, out;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .control(control), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .stat_zero(stat_zero), .stat_sign(stat_sign),
        .stat_overflow(stat_overflow), .stat_carry(stat_carry)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [W:0] wide;
        logic [2*W-1:0] p;
        e = '0;
        case (op)
            3'd0: begin
                wide = {1'b0, x} + {1'b0, y};
                e.val = wide[W-1:0];
                e.c = wide[W];
                e.v = (x[W-1] == y[W-1]) && (e.val[W-1] != x[W-1]);
            end
            3'd1: begin
                e.val = x - y;
                e.c = (x < y);
                e.v = (x[W-1] != y[W-1]) && (e.val[W-1] != x[W-1]);
            end
            3'd2: e.val = x | y;
            3'd3: e.val = x & y;
            3'd4: begin
                p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                e.val = p[W-1:0];
                e.v = (p[2*W-1:W] != '0);
            end
            3'd5: begin
                e.val = (y == '0) ? {W{1'b1}} : x / y;
                e.v = (y == '0);
            end
            3'd6: begin
                e.val = (y == '0) ? x : x % y;
                e.v = (y == '0);
            end
            default: e.v = 1'b1;
        endcase
        e.z = (e.val == '0);
        e.s = e.val[W-1];
        return e;
    endfunction

    function automatic exp_t observed();
        return {out, stat_zero, stat_sign, stat_overflow, stat_carry};
    endfunction

    task automatic send(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        control = op; a = x; b = y; in_valid = 1'b1;
        sb.push_back(model(op, x, y));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        control = '0; a = '0; b = '0;
        #12;
        vectors++;
        if ({in_ready, out_valid, observed()} !== {2'b10, {(W+4){1'b0}}}) begin
            miscompares++;
            $display("FAIL reset: got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=0", in_ready, out_valid, observed());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // shared body for the directed op tables below
    task automatic run_table(input string name, input logic [2:0] ops[], input logic [W-1:0] xs[], input logic [W-1:0] ys[]);
        int lat, want_lat;
        exp_t e;
        for (int i = 0; i < ops.size(); i++) begin
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL %s[%0d] in_ready: got %b want 1", name, i, in_ready);
            end
            send(ops[i], xs[i], ys[i]);
            wait_out(lat);
            want_lat = (ops[i] >= 3'd4 && ops[i] <= 3'd6) ? W + 1 : 1;
            vectors++;
            if (lat != want_lat) begin
                miscompares++;
                $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, want_lat);
            end
            e = sb.pop_front();
            vectors++;
            if (observed() !== e) begin
                miscompares++;
                $display("FAIL %s[%0d] result: got %h z%b s%b v%b c%b want %h z%b s%b v%b c%b", name, i,
                         out, stat_zero, stat_sign, stat_overflow, stat_carry, e.val, e.z, e.s, e.v, e.c);
            end
            take();
        end
    endtask

    task automatic test_alu_ops();
        run_table("alu", '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd7, 3'd0},
                  '{18'h1FFFF, 18'd5, 18'd3, 18'h30F00, 18'h3F0F0, 18'h12345, 18'h3FFFF},
                  '{18'h00001, 18'd5, 18'd5, 18'h000F1, 18'h0FFFF, 18'h00001, 18'h00001});
    endtask

    task automatic test_mul();
        run_table("mul", '{3'd4, 3'd4, 3'd4, 3'd4},
                  '{18'd300, 18'd1000, 18'h3FFFF, 18'd0},
                  '{18'd400, 18'd1000, 18'h3FFFF, 18'd777});
    endtask

    task automatic test_divrem();
        run_table("div", '{3'd5, 3'd6, 3'd5, 3'd6, 3'd5, 3'd6},
                  '{18'd1000, 18'd1000, 18'd1000, 18'd1000, 18'h3FFFF, 18'd5},
                  '{18'd7, 18'd7, 18'd0, 18'd0, 18'd1, 18'd9});
    endtask

    task automatic test_backpressure();
        int lat;
        exp_t e;
        send(3'd3, 18'h3F0F0, 18'h0FFFF);
        wait_out(lat);
        e = sb[0];
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if ({out_valid, in_ready, observed()} !== {2'b10, e}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b res=%h want vld=1 rdy=0 res=%h",
                         i, out_valid, in_ready, observed(), e);
            end
            @(posedge clk); #1;
        end
        void'(sb.pop_front());
        take();
        vectors++;
        if ({out_valid, in_ready, observed()} !== {2'b01, e}) begin
            miscompares++;
            $display("FAIL bp_release: got vld=%b rdy=%b res=%h want vld=0 rdy=1 res=%h",
                     out_valid, in_ready, observed(), e);
        end
    endtask

    task automatic test_flush();
        int lat;
        bit seen;
        exp_t prev, e;
        send(3'd2, 18'h00A50, 18'h10000);
        wait_out(lat);
        prev = sb.pop_front();
        take();
        send(3'd4, 18'd300, 18'd400);
        void'(sb.pop_back());
        repeat (4) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        vectors++;
        if ({in_ready, out_valid, observed()} !== {2'b10, prev}) begin
            miscompares++;
            $display("FAIL flush_busy: got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=%h",
                     in_ready, out_valid, observed(), prev);
        end
        seen = 1'b0;
        repeat (25) begin @(posedge clk); #1; seen |= out_valid; end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_no_result: got out_valid=1 want 0");
        end
        control = 3'd0; a = 18'd1; b = 18'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL flush_idle: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
        send(3'd0, 18'd7, 18'd8);
        wait_out(lat);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        e = sb.pop_front();
        vectors++;
        if ({out_valid, observed()} !== {1'b1, e}) begin
            miscompares++;
            $display("FAIL flush_done: got vld=%b res=%h want vld=1 res=%h", out_valid, observed(), e);
        end
        take();
    endtask

    task automatic test_reset_mid();
        send(3'd5, 18'd1000, 18'd7);
        void'(sb.pop_back());
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, observed()} !== {2'b10, {(W+4){1'b0}}}) begin
            miscompares++;
            $display("FAIL reset_mid: got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=0", in_ready, out_valid, observed());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_table("post_reset", '{3'd0}, '{18'd1234}, '{18'd4321});
    endtask

    task automatic test_back_to_back();
        int lat, want_lat;
        logic [2:0] op;
        logic [W-1:0] x, y;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(0, 7));
            x = W'($urandom);
            y = (i % 4 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            send(op, x, y);
            wait_out(lat);
            want_lat = (op >= 3'd4 && op <= 3'd6) ? W + 1 : 1;
            vectors++;
            if (lat != want_lat) begin
                miscompares++;
                $display("FAIL b2b[%0d] latency op%0d: got %0d want %0d", i, op, lat, want_lat);
            end
            e = sb.pop_front();
            vectors++;
            if (observed() !== e) begin
                miscompares++;
                $display("FAIL b2b[%0d] op%0d %h,%h: got %h want %h", i, op, x, y, observed(), e);
            end
            take();
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_mul();
        test_divrem();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the datapath execute stage. It extends the add/subtract/or/and unit with iterative unsigned multiply, divide and remainder, a carry flag, and a valid/ready handshake on both sides. Operands and the opcode are captured on input acceptance. The result and status flags are held in registers until the consumer takes them.

## Interface
- WIDTH, 18: operand/result width in bits; must be ≥ 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept an operation; high only in IDLE.
- control  in  3  opcode: 000 add, 001 subtract, 010 or, 011 and, 100 mul, 101 div, 110 rem, 111 reserved.
- a, b  in  WIDTH  operands.
- flush  in  1  synchronous abort of the current operation.
- out_valid  out  1  result and status valid.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  result.
- stat_zero, stat_sign, stat_overflow, stat_carry  out  1 each  status flags.

## Operation
- **States:** IDLE, BUSY, DONE.
- **Accept:** in_valid && in_ready in IDLE latches a, b and control.
  - Opcodes 000–011 and 111: compute from the latched values and go to DONE.
  - Opcodes 100–110: go to BUSY with the iteration counter set to WIDTH.
- **BUSY:** one iteration per cycle; the counter decrements each cycle. When the counter reaches 0, write the result and go to DONE.
  - Multiply: shift-add, 2·WIDTH-bit product.
  - Divide: restoring, quotient and remainder.
- **DONE:** out_valid=1, with out and the stat flags stable. When out_ready=1, go to IDLE; out and the flags keep their last values.
- **Result rules:**
  - add: out = (a+b) mod 2^WIDTH. carry = bit WIDTH of the sum. overflow = signed overflow, i.e. a[MSB]==b[MSB] and out[MSB]!=a[MSB].
  - subtract: out = (a−b) mod 2^WIDTH. carry = borrow (a<b unsigned). overflow = a[MSB]!=b[MSB] and out[MSB]!=a[MSB].
  - or / and: bitwise. carry=0, overflow=0.
  - mul: out = low WIDTH bits of a·b (unsigned). overflow=1 if the high WIDTH bits are nonzero. carry=0.
  - div: out = a/b (unsigned). rem: out = a mod b. carry=0, overflow=0.
  - divide by zero (b=0): div out = all ones; rem out = a; overflow=1. Full BUSY latency still applies.
  - reserved (111): out=0, overflow=1, carry=0.
  - All opcodes: zero = (out==0); sign = out[WIDTH−1].
- **flush:**
  - In BUSY: abort, go to IDLE. No out_valid; out and the flags are unchanged.
  - In IDLE or DONE: ignored. A DONE result is never dropped.
  - When flush and in_valid are both high in IDLE, flush has priority and nothing is accepted.

## Timing
- **Reset** (rst_n low, asynchronous): state=IDLE, counter=0, out=0, all stat flags 0, out_valid=0. in_ready=1 once state is IDLE.
- **Latency** (accept edge to out_valid high):
  - 1 cycle for 000–011 and 111.
  - WIDTH+1 cycles for 100–110.
- **Throughput:** in_ready=0 in BUSY and DONE, so operations never overlap. The next accept is possible no earlier than the cycle after the output handshake.
- **Handshake:** out_valid stays high until out_ready is sampled high. out and the flags must not change while out_valid=1.
- **Counter:** $clog2(WIDTH+1) bits; it must not wrap below 0.
- **Reset mid-operation:** an asynchronous rst_n low in any state forces the reset values immediately. Nothing in flight survives.

## Test plan
- **Add and flags (WIDTH=18):** a=0x1FFFF, b=0x00001, add → out=0x20000, overflow=1, sign=1, carry=0, zero=0, out_valid one cycle after accept.
- **Subtract, both flag cases:**
  - a=5, b=5 → out=0, zero=1, carry=0.
  - a=3, b=5 → out=0x3FFFE, carry=1, sign=1, overflow=0.
- **Multiply:**
  - 300·400 → out=0x1D4C0, overflow=0, out_valid 19 cycles after accept.
  - 1000·1000 → out=213568, overflow=1.
- **Divide / remainder:**
  - 1000 div 7 → 142; 1000 rem 7 → 6.
  - b=0: div → 0x3FFFF with overflow=1; rem → 1000 with overflow=1.
- **Backpressure:** hold out_ready=0 for 10 cycles after an and-op result. out_valid, out and flags stay stable and in_ready=0. Raise out_ready → IDLE next cycle; a new op is accepted after that.
- **Abort and reset:**
  - flush at BUSY cycle 5 of a mul → IDLE, no out_valid, previous out unchanged.
  - rst_n low mid-div → immediate reset values; a subsequent add completes normally.
